// File: rtl/weight_loader_pkg.sv
// Shared types and helpers for the secure weight loader: FSM states,
// error codes and the per-byte decrypt primitive.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_CHECK  = 2'b11
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CSUM  = 2'b01;
  localparam logic [1:0] ERR_MODEL = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  // plain = rotate-left-1(cipher XOR key)
  function automatic logic [7:0] decrypt_byte(input logic [7:0] cipher, input logic [7:0] k);
    logic [7:0] x;
    x = cipher ^ k;
    return {x[6:0], x[7]};
  endfunction

endpackage

// File: rtl/wl_decrypt_stage.sv
// Registered N-bit decrypt stage: every byte of the word is decrypted
// independently and the result is captured on the next rising edge.
module wl_decrypt_stage
  import weight_loader_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic [7:0]   key,
  output logic         out_valid,
  output logic [N-1:0] out_data
);

  logic [N-1:0] plain;

  genvar gi;
  generate
    for (gi = 0; gi < N / 8; gi++) begin : g_byte
      assign plain[gi*8 +: 8] = decrypt_byte(in_data[gi*8 +: 8], key);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid & ~flush;
      if (in_valid) begin
        out_data <= plain;
      end
    end
  end

endmodule

// File: rtl/secure_weight_loader.sv
// Streams one encrypted ROM channel through the decrypt stage into a local
// weight memory, checksums the plaintext and reports the outcome.
module secure_weight_loader
  import weight_loader_pkg::*;
#(
  parameter int N          = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_MODELS = 2,
  parameter int CSUM_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [7:0]                    key,
  input  logic [$clog2(NUM_MODELS)-1:0] model_sel,
  input  logic [NUM_MODELS*N-1:0]       rom_data,
  input  logic [CSUM_W-1:0]             expected_csum,
  output logic [$clog2(DEPTH)-1:0]      rom_addr,
  output logic                          rom_en,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr,
  output logic [N-1:0]                  rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          weights_valid,
  output logic [1:0]                    err_code,
  output logic [$clog2(NUM_MODELS)-1:0] loaded_model
);

  localparam int SEL_W  = $clog2(NUM_MODELS);
  localparam int ADDR_W = $clog2(DEPTH);

  state_t             state;
  logic [7:0]         key_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               sel_ok_reg;
  logic               sel_in_range;
  logic               flush;
  logic               rom_valid_reg;
  logic [N-1:0]       rom_word;
  logic               dec_valid;
  logic [N-1:0]       dec_data;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic [CSUM_W-1:0]  csum_reg;
  logic [N-1:0]       mem [DEPTH];

  assign sel_in_range = (32'(model_sel) < NUM_MODELS);
  assign flush        = abort && (state != ST_IDLE);

  always_comb begin
    rom_word = '0;
    for (int i = 0; i < NUM_MODELS; i++) begin
      if (sel_reg == SEL_W'(i)) begin
        rom_word = rom_data[i*N +: N];
      end
    end
  end

  // rom_en delayed by the ROM read latency marks rom_data as live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_valid_reg <= 1'b0;
    end else begin
      rom_valid_reg <= rom_en & ~flush;
    end
  end

  wl_decrypt_stage #(.N(N)) u_decrypt (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (rom_valid_reg),
    .in_data   (rom_word),
    .key       (key_reg),
    .out_valid (dec_valid),
    .out_data  (dec_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_reg    <= '0;
      wr_addr_reg <= '0;
    end else if (state == ST_IDLE && start) begin
      csum_reg    <= '0;
      wr_addr_reg <= '0;
    end else if (dec_valid) begin
      csum_reg    <= csum_reg + CSUM_W'(dec_data);
      wr_addr_reg <= wr_addr_reg + 1'b1;
    end
  end

  // Weight memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (dec_valid) begin
      mem[wr_addr_reg] <= dec_data;
    end
  end

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rom_addr      <= '0;
      rom_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      weights_valid <= 1'b0;
      err_code      <= ERR_NONE;
      loaded_model  <= '0;
      key_reg       <= '0;
      sel_reg       <= '0;
      sel_ok_reg    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // abort wins over any completion in the same cycle
        state         <= ST_IDLE;
        rom_addr      <= '0;
        rom_en        <= 1'b0;
        busy          <= 1'b0;
        weights_valid <= 1'b0;
        err_code      <= ERR_ABORT;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              key_reg       <= key;
              sel_reg       <= model_sel;
              sel_ok_reg    <= sel_in_range;
              weights_valid <= 1'b0;
              err_code      <= ERR_NONE;
              rom_addr      <= '0;
              rom_en        <= sel_in_range;
              busy          <= 1'b1;
              state         <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            if (!sel_ok_reg) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              err_code <= ERR_MODEL;
            end else if (rom_addr == ADDR_W'(DEPTH - 1)) begin
              state    <= ST_DRAIN;
              rom_en   <= 1'b0;
              rom_addr <= '0;
            end else begin
              rom_addr <= rom_addr + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (!rom_valid_reg && !dec_valid) begin
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (csum_reg != expected_csum) begin
              err_code      <= ERR_CSUM;
              weights_valid <= 1'b0;
            end else begin
              weights_valid <= 1'b1;
              loaded_model  <= sel_reg;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_secure_weight_loader.sv
// Directed bench for secure_weight_loader with a cycle-count reference model
// and per-cycle output comparison.
module tb_secure_weight_loader;

  localparam int N = 8, DEPTH = 16, NM = 3, CSUM_W = 16;
  localparam int LAT = DEPTH + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [7:0]  key;
  logic [1:0]  model_sel;
  logic [NM*N-1:0] rom_data;
  logic [15:0] expected_csum;
  logic [3:0]  rom_addr;
  logic        rom_en;
  logic [3:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        busy, done, weights_valid;
  logic [1:0]  err_code, loaded_model;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  secure_weight_loader #(.N(N), .DEPTH(DEPTH), .NUM_MODELS(NM), .CSUM_W(CSUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key),
    .model_sel(model_sel), .rom_data(rom_data), .expected_csum(expected_csum),
    .rom_addr(rom_addr), .rom_en(rom_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .weights_valid(weights_valid), .err_code(err_code),
    .loaded_model(loaded_model)
  );

  // Encrypted ROMs with one cycle of read latency
  logic [7:0] rom_mem [NM][DEPTH];
  logic [7:0] rom_q [NM];
  always @(posedge clk) begin
    if (rom_en) begin
      for (int c = 0; c < NM; c++) rom_q[c] <= rom_mem[c][rom_addr];
    end
  end
  assign rom_data = {rom_q[2], rom_q[1], rom_q[0]};

  always @(posedge clk) rd_addr <= rd_addr + 4'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dec8(input logic [7:0] c, input logic [7:0] k);
    logic [7:0] x;
    x = c ^ k;
    return 8'((x << 1) | (x >> 7));
  endfunction

  function automatic logic [7:0] chan_word(input logic [1:0] sel, input int i);
    if (sel < 2'(NM)) return rom_mem[sel][i];
    return 8'h00;
  endfunction

  function automatic logic [15:0] model_sum(input logic [7:0] p [DEPTH]);
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += int'(p[i]);
    return 16'(s);
  endfunction

  function automatic logic [15:0] csum_of(input logic [1:0] sel, input logic [7:0] k);
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += int'(dec8(chan_word(sel, i), k));
    return 16'(s);
  endfunction

  // Reference model: behaviour expressed as cycles elapsed since the start edge
  logic       m_busy, m_done, m_rom_en, m_valid, m_bad;
  logic [3:0] m_rom_addr;
  logic [1:0] m_err, m_loaded, m_sel;
  int         m_cnt;
  logic [7:0] m_plain [DEPTH];
  logic [7:0] m_mem [DEPTH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_rom_en <= 0; m_rom_addr <= 0;
      m_valid <= 0; m_err <= 0; m_loaded <= 0; m_cnt <= 0; m_bad <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy && abort) begin
        m_busy <= 0; m_rom_en <= 0; m_rom_addr <= 0; m_err <= 2'b11; m_valid <= 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy <= 1; m_cnt <= 0; m_err <= 2'b00; m_valid <= 0;
          m_sel <= model_sel;
          m_bad <= (model_sel >= 2'(NM));
          m_rom_en <= (model_sel < 2'(NM));
          m_rom_addr <= 0;
          for (int i = 0; i < DEPTH; i++) m_plain[i] <= dec8(chan_word(model_sel, i), key);
        end
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_bad) begin
          m_busy <= 0; m_done <= 1; m_err <= 2'b10;
        end else begin
          m_rom_en   <= (m_cnt + 1 <= DEPTH - 1);
          m_rom_addr <= (m_cnt + 1 <= DEPTH - 1) ? 4'(m_cnt + 1) : 4'd0;
          if (m_cnt + 1 == LAT) begin
            m_busy <= 0; m_done <= 1;
            if (model_sum(m_plain) == expected_csum) begin
              m_valid <= 1; m_loaded <= m_sel; m_mem <= m_plain;
            end else begin
              m_err <= 2'b01;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("rom_en", 32'(rom_en), 32'(m_rom_en));
    chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    chk("weights_valid", 32'(weights_valid), 32'(m_valid));
    chk("err_code", 32'(err_code), 32'(m_err));
    chk("loaded_model", 32'(loaded_model), 32'(m_loaded));
    if (m_valid) chk("rd_data", 32'(rd_data), 32'(m_mem[rd_addr]));
  end

  task automatic run(input logic [1:0] sel, input logic [7:0] k, input logic [15:0] cs,
                     output int lat, output bit en_seen);
    @(negedge clk);
    model_sel = sel; key = k; expected_csum = cs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    en_seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      en_seen = en_seen | rom_en;
      if (done) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done, expected one within 60 cycles");
    end
    $display("load sel=%0d key=%02h csum=%04h -> latency=%0d err=%0d valid=%0d",
             sel, k, cs, lat, err_code, weights_valid);
  endtask

  task automatic wait_rd(input logic [3:0] a);
    for (int c = 0; c < DEPTH; c++) begin
      if (rd_addr == a) break;
      @(negedge clk);
    end
  endtask

  int lat, dcount;
  bit en_seen;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom_mem[0][i] = 8'h00;
      rom_mem[1][i] = 8'(i);
      rom_mem[2][i] = 8'hF0 ^ 8'(i * 7);
    end
    rst_n = 1'b0; start = 0; abort = 0; key = 0; model_sel = 0; expected_csum = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_code), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // key A5, all-zero channel 0 -> every weight 4B, checksum 16*4B
    run(2'd0, 8'hA5, 16'h04B0, lat, en_seen);
    chk("t1_latency", 32'(lat), 32'(LAT));
    chk("t1_err", 32'(err_code), 0);
    chk("t1_valid", 32'(weights_valid), 1);
    repeat (DEPTH) begin
      @(negedge clk);
      chk("t1_weight", 32'(rd_data), 32'h4B);
    end

    // checksum off by one
    run(2'd0, 8'hA5, 16'h04B1, lat, en_seen);
    chk("t2_latency", 32'(lat), 32'(LAT));
    chk("t2_err", 32'(err_code), 32'h1);
    chk("t2_valid", 32'(weights_valid), 0);

    // channel 1 holds 0..15; key 3C maps them onto rotl of 30..3F
    run(2'd1, 8'h3C, 16'h06F0, lat, en_seen);
    chk("t3_valid", 32'(weights_valid), 1);
    chk("t3_loaded", 32'(loaded_model), 1);
    wait_rd(4'd0);
    chk("t3_w0", 32'(rd_data), 32'h78);
    @(negedge clk);
    chk("t3_w1", 32'(rd_data), 32'h7A);

    // out-of-range channel
    run(2'd3, 8'h11, 16'h0000, lat, en_seen);
    chk("t4_latency", 32'(lat), 1);
    chk("t4_err", 32'(err_code), 32'h2);
    chk("t4_rom_en_seen", 32'(en_seen), 0);
    chk("t4_valid", 32'(weights_valid), 0);

    // abort sampled on the fifth edge after start
    @(negedge clk);
    model_sel = 2'd0; key = 8'hA5; expected_csum = 16'h04B0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_err", 32'(err_code), 32'h3);
    chk("t5_rom_en", 32'(rom_en), 0);
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("t5_no_done", 32'(dcount), 0);
    $display("abort at stream cycle 5 -> err=%0d done_pulses=%0d", err_code, dcount);
    run(2'd0, 8'hA5, 16'h04B0, lat, en_seen);
    chk("t5_restart_err", 32'(err_code), 0);
    chk("t5_restart_valid", 32'(weights_valid), 1);

    // start held high: ignored while busy, retriggers once back in IDLE
    @(negedge clk);
    model_sel = 2'd1; key = 8'h3C; expected_csum = 16'h06F0; start = 1'b1;
    lat = -1;
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin lat = c; break; end
    end
    chk("t6_first_latency", 32'(lat), 32'(LAT));
    @(negedge clk);
    start = 1'b0;
    chk("t6_rebusy", 32'(busy), 1);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin lat = c; break; end
    end
    chk("t6_second_latency", 32'(lat), 32'(LAT));
    $display("held start -> second load latency=%0d valid=%0d", lat, weights_valid);

    // channel 2 with a bench-computed checksum
    run(2'd2, 8'h5A, csum_of(2'd2, 8'h5A), lat, en_seen);
    chk("t7_valid", 32'(weights_valid), 1);
    chk("t7_loaded", 32'(loaded_model), 2);

    // asynchronous reset during DRAIN
    @(negedge clk);
    model_sel = 2'd1; key = 8'h3C; expected_csum = 16'h06F0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    chk("t8_pre_busy", 32'(busy), 1);
    chk("t8_pre_rom_en", 32'(rom_en), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_busy", 32'(busy), 0);
    chk("t8_done", 32'(done), 0);
    chk("t8_valid", 32'(weights_valid), 0);
    chk("t8_err", 32'(err_code), 0);
    chk("t8_loaded", 32'(loaded_model), 0);
    chk("t8_rom_addr", 32'(rom_addr), 0);
    $display("reset mid-drain -> busy=%0d err=%0d loaded=%0d", busy, err_code, loaded_model);
    @(negedge clk);
    rst_n = 1'b1;
    run(2'd0, 8'hA5, 16'h04B0, lat, en_seen);
    chk("t9_latency", 32'(lat), 32'(LAT));
    chk("t9_valid", 32'(weights_valid), 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/secure_weight_loader.md
SECURE_WEIGHT_LOADER -- requirements
Module: secure_weight_loader

Interface
REQ-001 SHALL have parameter N, default 8: weight width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16: weights per model; must be at least 2.
REQ-003 SHALL have parameter NUM_MODELS, default 2: number of encrypted ROM channels; must be at least 2.
REQ-004 SHALL have parameter CSUM_W, default 16: checksum width.
REQ-005 SHALL use clock clk, input, 1 bit: one clock domain, rising edge.
REQ-006 SHALL use reset rst_n, input, 1 bit: asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: load request, sampled in IDLE.
REQ-008 SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-009 SHALL have port key, input, 8 bits: symmetric decrypt key.
REQ-010 SHALL have port model_sel, input, $clog2(NUM_MODELS) bits: ROM channel index.
REQ-011 SHALL have port rom_data, input, NUM_MODELS*N bits: flattened ROM outputs; channel i occupies bits [i*N +: N].
REQ-012 SHALL have port expected_csum, input, CSUM_W bits: reference checksum.
REQ-013 SHALL have port rom_addr, output, $clog2(DEPTH) bits: common ROM address.
REQ-014 SHALL have port rom_en, output, 1 bit: ROM read enable; ROMs have 1-cycle read latency.
REQ-015 SHALL have port rd_addr, input, $clog2(DEPTH) bits: weight readout address.
REQ-016 SHALL have port rd_data, output, N bits: stored weight at rd_addr, combinational.
REQ-017 SHALL have port busy, output, 1 bit: high outside IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse at load completion.
REQ-019 SHALL have port weights_valid, output, 1 bit: stored weights are complete and checksum-clean.
REQ-020 SHALL have port err_code, output, 2 bits: 00 none, 01 checksum, 10 bad model, 11 aborted.
REQ-021 SHALL have port loaded_model, output, $clog2(NUM_MODELS) bits: channel of the last successful load.

Function
REQ-022 SHALL implement FSM states IDLE, STREAM, DRAIN, CHECK, with transitions IDLE->STREAM->DRAIN->CHECK->IDLE.
REQ-023 SHALL, on start in IDLE, latch model_sel and key, clear weights_valid, clear err_code, and clear the checksum accumulator.
REQ-024 SHALL, if the latched model_sel >= NUM_MODELS, return to IDLE next cycle with err_code=10, pulse done, and perform no ROM reads.
REQ-025 SHALL, in STREAM, hold rom_en=1 and issue rom_addr 0..DEPTH-1 on consecutive cycles, one per cycle.
REQ-026 SHALL drive rom_addr=0 and rom_en=0 outside STREAM.
REQ-027 SHALL decrypt each byte of a word independently: plain_byte = rotate-left-1(cipher_byte XOR key).
REQ-028 SHALL register the decrypt stage, and write each decrypted word to memory the cycle after decryption.
REQ-029 SHALL, in DRAIN, wait until the last word is written.
REQ-030 SHALL accumulate the checksum as the sum of zero-extended decrypted words modulo 2^CSUM_W, wrapping silently on overflow.
REQ-031 SHALL, in CHECK, set err_code=01 and weights_valid=0 if checksum != expected_csum; otherwise set weights_valid=1 and loaded_model=latched channel.
REQ-032 SHALL, in CHECK, pulse done, then go to IDLE.
REQ-033 SHALL assert done exactly DEPTH+4 cycles after the clock edge that sampled start (fixed latency).
REQ-034 SHALL ignore start while busy.
REQ-035 SHALL accept a start held high across the return to IDLE as a new request.
REQ-036 SHALL, on abort in STREAM, DRAIN or CHECK, enter IDLE next cycle with rom_en=0, err_code=11 and weights_valid=0, without pulsing done.
REQ-037 SHALL give abort priority over completion in the same cycle.
REQ-038 SHALL leave partially written memory contents undefined for use.
REQ-039 SHALL keep rd_data readable at all times.

Reset
REQ-040 SHALL, on rst_n low, immediately force: state=IDLE, rom_addr=0, rom_en=0, busy=0, done=0, weights_valid=0, err_code=00, loaded_model=0, checksum=0.
REQ-041 SHALL NOT reset the weight memory.
REQ-042 SHALL treat reset mid-load as an abort without an error code.

Structure
REQ-043 SHALL place the state enum, err_code constants and the byte-decrypt function in package weight_loader_pkg.
REQ-044 SHALL implement the registered N-bit decrypt stage as sub-module wl_decrypt_stage.

Verification
REQ-045 SHALL verify: key=8'hA5, channel 0 all 8'h00, correct expected_csum -> every weight 8'h4B, weights_valid=1, err_code=00, done at cycle DEPTH+4.
REQ-046 SHALL verify: model_sel=1 with distinct ROM contents per channel -> channel-1 plaintext stored, loaded_model=1.
REQ-047 SHALL verify: expected_csum off by one -> err_code=01, weights_valid=0, done pulses.
REQ-048 SHALL verify: NUM_MODELS=3, model_sel=3 -> err_code=10, rom_en never high.
REQ-049 SHALL verify: abort at STREAM cycle 5 -> IDLE next cycle, err_code=11, no done; a following start completes cleanly.
REQ-050 SHALL verify: rst_n low mid-DRAIN -> all outputs at reset values asynchronously, err_code=00.
